// File: rtl/axi_tagctrl_pkg.sv
// Shared types and width helpers for the CHERI tag controller read path.
package axi_tagctrl_pkg;

    typedef struct packed {
        int unsigned AxiAddrWidth;
        int unsigned AxiDataWidth;
        int unsigned AxiIdWidth;
        int unsigned CapSize;
    } tagctrl_cfg_t;

    // Channel structs below are sized from this configuration.
    localparam tagctrl_cfg_t DefaultCfg = '{
        AxiAddrWidth: 32, AxiDataWidth: 64, AxiIdWidth: 4, CapSize: 128
    };

    localparam int unsigned AddrW = DefaultCfg.AxiAddrWidth;
    localparam int unsigned DataW = DefaultCfg.AxiDataWidth;
    localparam int unsigned IdW   = DefaultCfg.AxiIdWidth;

    // Byte offset inside one capability, and capability index inside one tag word.
    localparam int unsigned TagOffW = $clog2(DefaultCfg.CapSize / 8);
    localparam int unsigned TagIdxW = $clog2(DefaultCfg.AxiDataWidth);
    localparam int unsigned TagLowW = TagOffW + TagIdxW;

    localparam logic [1:0] RespOkay = 2'b00;

    typedef struct packed {
        logic [IdW-1:0]   a_x_id;
        logic [AddrW-1:0] a_x_addr;
        logic [7:0]       a_x_len;
        logic [2:0]       a_x_size;
        logic [1:0]       a_x_burst;
    } tagctrl_desc_t;

    typedef struct packed {
        logic [AddrW-1:0] addr;
    } tagc_req_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [1:0]       resp;
    } tagc_rsp_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic             user;
    } r_chan_t;

    typedef enum logic [1:0] {
        IDLE,
        TAG_REQ,
        TAG_WAIT,
        STREAM
    } rd_state_e;

endpackage

// File: rtl/axi_tagctrl_r_skid.sv
// Two-entry registered skid buffer for tagged R beats. Accepts a beat
// whenever an entry is free, so one entry in flight sustains 1 beat/cycle.
module axi_tagctrl_r_skid
    import axi_tagctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  r_chan_t push_beat,
    input  logic    push_valid,
    output logic    push_ready,
    output r_chan_t pop_beat,
    output logic    pop_valid,
    input  logic    pop_ready
);

    r_chan_t    mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign push_ready = (cnt_q != 2'd2);
    assign pop_valid  = (cnt_q != 2'd0);
    assign pop_beat   = mem_q[rd_q];
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    // Pointer and occupancy tracking; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_beat;
    end

endmodule

// File: rtl/axi_tagctrl_r.sv
// Read half of the CHERI tag controller: fetches the tag word covering the
// burst, then forwards memory R beats with each capability's tag in r.user.
module axi_tagctrl_r
    import axi_tagctrl_pkg::*;
#(
    parameter tagctrl_cfg_t Cfg = DefaultCfg
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  tagctrl_desc_t tagctrl_desc_i,
    input  logic          tagctrl_desc_valid_i,
    output logic          tagctrl_desc_ready_o,
    output tagc_req_t     tagc_req_o,
    output logic          tagc_req_valid_o,
    input  logic          tagc_req_ready_i,
    input  tagc_rsp_t     tagc_rsp_i,
    input  logic          tagc_rsp_valid_i,
    output logic          tagc_rsp_ready_o,
    input  r_chan_t       r_chan_mst_i,
    input  logic          r_chan_mst_valid_i,
    output logic          r_chan_mst_ready_o,
    output r_chan_t       r_chan_slv_o,
    output logic          r_chan_slv_valid_o,
    input  logic          r_chan_slv_ready_i
);

    localparam int unsigned OffW = $clog2(Cfg.CapSize / 8);
    localparam int unsigned IdxW = $clog2(Cfg.AxiDataWidth);
    localparam int unsigned LowW = OffW + IdxW;

    rd_state_e        state_q, state_d;
    logic [IdW-1:0]   id_q;
    logic [AddrW-1:0] addr_q;
    logic [7:0]       len_q;
    logic [7:0]       beat_q;
    logic [2:0]       size_q;
    logic [DataW-1:0] tag_q;
    logic [1:0]       tag_resp_q;

    logic             desc_fire;
    logic             rsp_fire;
    logic             beat_fire;
    logic             last_beat;
    logic             word_cross;
    logic [AddrW-1:0] step;
    logic [AddrW-1:0] next_addr;
    logic [IdxW-1:0]  idx;
    logic             skid_ready;
    r_chan_t          skid_beat;

    // Burst id/user/last of the memory beat are regenerated locally; INCR is implied.
    logic unused_ok;
    assign unused_ok = ^{r_chan_mst_i.id, r_chan_mst_i.last, r_chan_mst_i.user,
                         tagctrl_desc_i.a_x_burst};

    assign desc_fire  = tagctrl_desc_valid_i && (state_q == IDLE);
    assign rsp_fire   = tagc_rsp_valid_i && (state_q == TAG_WAIT);
    assign beat_fire  = r_chan_mst_valid_i && skid_ready && (state_q == STREAM);
    assign last_beat  = (beat_q == len_q);
    assign idx        = addr_q[OffW +: IdxW];
    assign step       = AddrW'(1) << size_q;
    assign next_addr  = (addr_q + step) & ~(step - AddrW'(1));
    // Next beat starts a new tag word: fetch it before accepting that beat.
    assign word_cross = (next_addr[LowW-1:0] == '0);

    assign tagc_req_o.addr = {addr_q[AddrW-1:LowW], {LowW{1'b0}}};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d              = state_q;
        tagctrl_desc_ready_o = 1'b0;
        tagc_req_valid_o     = 1'b0;
        tagc_rsp_ready_o     = 1'b0;
        r_chan_mst_ready_o   = 1'b0;
        case (state_q)
            IDLE: begin
                tagctrl_desc_ready_o = 1'b1;
                if (tagctrl_desc_valid_i) state_d = TAG_REQ;
            end
            TAG_REQ: begin
                tagc_req_valid_o = 1'b1;
                if (tagc_req_ready_i) state_d = TAG_WAIT;
            end
            TAG_WAIT: begin
                tagc_rsp_ready_o = 1'b1;
                if (tagc_rsp_valid_i) state_d = STREAM;
            end
            STREAM: begin
                r_chan_mst_ready_o = skid_ready;
                if (beat_fire) begin
                    if (last_beat)       state_d = IDLE;
                    else if (word_cross) state_d = TAG_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Descriptor, address stepping and tag word registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_q     <= '0;
            tag_q      <= '0;
            tag_resp_q <= '0;
        end else begin
            if (desc_fire) begin
                id_q   <= tagctrl_desc_i.a_x_id;
                addr_q <= tagctrl_desc_i.a_x_addr;
                len_q  <= tagctrl_desc_i.a_x_len;
                size_q <= tagctrl_desc_i.a_x_size;
                beat_q <= '0;
            end
            if (rsp_fire) begin
                tag_q      <= tagc_rsp_i.data;
                tag_resp_q <= tagc_rsp_i.resp;
            end
            if (beat_fire) begin
                addr_q <= next_addr;
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    // Tagged beat: memory error wins, then tag-fetch error, else OKAY.
    always_comb begin
        skid_beat      = '0;
        skid_beat.id   = id_q;
        skid_beat.data = r_chan_mst_i.data;
        skid_beat.last = last_beat;
        skid_beat.user = tag_q[idx];
        if (r_chan_mst_i.resp != RespOkay) skid_beat.resp = r_chan_mst_i.resp;
        else                               skid_beat.resp = tag_resp_q;
    end

    axi_tagctrl_r_skid u_skid (
        .clk        (clk_i),
        .rst        (rst_i),
        .push_beat  (skid_beat),
        .push_valid (r_chan_mst_valid_i && (state_q == STREAM)),
        .push_ready (skid_ready),
        .pop_beat   (r_chan_slv_o),
        .pop_valid  (r_chan_slv_valid_o),
        .pop_ready  (r_chan_slv_ready_i)
    );

endmodule

// File: tb/tb_axi_tagctrl_r.sv
// Directed bench for axi_tagctrl_r: tag cache and memory models, slave sink.
module tb_axi_tagctrl_r;
    import axi_tagctrl_pkg::*;

    logic          clk;
    logic          rst_i;
    tagctrl_desc_t tagctrl_desc_i;
    logic          tagctrl_desc_valid_i;
    logic          tagctrl_desc_ready_o;
    tagc_req_t     tagc_req_o;
    logic          tagc_req_valid_o;
    logic          tagc_req_ready_i;
    tagc_rsp_t     tagc_rsp_i;
    logic          tagc_rsp_valid_i;
    logic          tagc_rsp_ready_o;
    r_chan_t       r_chan_mst_i;
    logic          r_chan_mst_valid_i;
    logic          r_chan_mst_ready_o;
    r_chan_t       r_chan_slv_o;
    logic          r_chan_slv_valid_o;
    logic          r_chan_slv_ready_i;

    axi_tagctrl_r dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .tagctrl_desc_i       (tagctrl_desc_i),
        .tagctrl_desc_valid_i (tagctrl_desc_valid_i),
        .tagctrl_desc_ready_o (tagctrl_desc_ready_o),
        .tagc_req_o           (tagc_req_o),
        .tagc_req_valid_o     (tagc_req_valid_o),
        .tagc_req_ready_i     (tagc_req_ready_i),
        .tagc_rsp_i           (tagc_rsp_i),
        .tagc_rsp_valid_i     (tagc_rsp_valid_i),
        .tagc_rsp_ready_o     (tagc_rsp_ready_o),
        .r_chan_mst_i         (r_chan_mst_i),
        .r_chan_mst_valid_i   (r_chan_mst_valid_i),
        .r_chan_mst_ready_o   (r_chan_mst_ready_o),
        .r_chan_slv_o         (r_chan_slv_o),
        .r_chan_slv_valid_o   (r_chan_slv_valid_o),
        .r_chan_slv_ready_i   (r_chan_slv_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } mbeat_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model state shared between the bus process and the test sequence.
    tagc_rsp_t     tagw_q[$];
    mbeat_t        mem_q[$];
    r_chan_t       got_q[$];
    logic [31:0]   req_log[$];
    int            got_req[$];
    int            req_cyc[$], rsp_cyc[$], mst_cyc[$], slv_cyc[$];
    int            cyc = 0;
    int            desc_cyc = 0;
    tagc_rsp_t     cur_rsp = '0;
    bit            rsp_go = 0, rsp_pend = 0, desc_pend = 0, slv_hold = 0;
    tagctrl_desc_t desc_v = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        tagw_q.delete(); mem_q.delete(); got_q.delete(); req_log.delete();
        got_req.delete(); req_cyc.delete(); rsp_cyc.delete();
        mst_cyc.delete(); slv_cyc.delete();
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
        mbeat_t b;
        b.data = d; b.resp = r; b.last = l;
        mem_q.push_back(b);
    endtask

    task automatic push_tag(input logic [63:0] d, input logic [1:0] r);
        tagc_rsp_t t;
        t.data = d; t.resp = r;
        tagw_q.push_back(t);
    endtask

    task automatic send_desc(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        desc_v.a_x_id    = id;
        desc_v.a_x_addr  = addr;
        desc_v.a_x_len   = len;
        desc_v.a_x_size  = 3'd3;
        desc_v.a_x_burst = 2'b01;
        desc_pend = 1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got_q.size() < n) chk("timeout_beats", 64'(got_q.size()), 64'(n));
        repeat (3) step();
    endtask

    // Bus models: sample handshakes at negedge, drive new values just after posedge.
    always begin
        @(negedge clk);
        cyc++;
        if (rst_i) begin
            rsp_go = 0; rsp_pend = 0;
        end else begin
            if (tagctrl_desc_valid_i && tagctrl_desc_ready_o) begin
                desc_pend = 0;
                desc_cyc  = cyc;
            end
            if (tagc_req_valid_o && tagc_req_ready_i) begin
                req_log.push_back(tagc_req_o.addr);
                req_cyc.push_back(cyc);
                cur_rsp = (tagw_q.size() > 0) ? tagw_q.pop_front() : '0;
                rsp_go  = 1;
            end
            if (tagc_rsp_valid_i && tagc_rsp_ready_o) begin
                rsp_pend = 0;
                rsp_cyc.push_back(cyc);
            end
            if (r_chan_mst_valid_i && r_chan_mst_ready_o) begin
                void'(mem_q.pop_front());
                mst_cyc.push_back(cyc);
                got_req.push_back(req_log.size());
            end
            if (r_chan_slv_valid_o && r_chan_slv_ready_i) begin
                got_q.push_back(r_chan_slv_o);
                slv_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (rsp_go) begin rsp_pend = 1; rsp_go = 0; end
        tagctrl_desc_valid_i = desc_pend;
        tagctrl_desc_i       = desc_v;
        tagc_req_ready_i     = 1'b1;
        tagc_rsp_valid_i     = rsp_pend;
        tagc_rsp_i           = rsp_pend ? cur_rsp : '0;
        r_chan_mst_valid_i   = (mem_q.size() > 0);
        r_chan_mst_i         = '0;
        if (mem_q.size() > 0) begin
            r_chan_mst_i.data = mem_q[0].data;
            r_chan_mst_i.resp = mem_q[0].resp;
            r_chan_mst_i.last = mem_q[0].last;
        end
        r_chan_slv_ready_i = !slv_hold;
    end

    // Single aligned beat; also checks the three handshake latencies.
    task automatic test1();
        clr();
        push_tag(64'h2, 2'b00);
        push_beat(64'hA1, 2'b00, 1'b1);
        send_desc(4'h3, 32'h1010, 8'd0);
        wait_beats(1, 50);
        chk("t1_req_addr", req_log[0], 32'h1000);
        chk("t1_user", got_q[0].user, 1);
        chk("t1_last", got_q[0].last, 1);
        chk("t1_resp", got_q[0].resp, 0);
        chk("t1_id", got_q[0].id, 3);
        chk("t1_data", got_q[0].data, 64'hA1);
        chk("t1_lat_desc2req", 64'(req_cyc[0] - desc_cyc), 1);
        chk("t1_lat_rsp2mst", 64'(mst_cyc[0] - rsp_cyc[0]), 1);
        chk("t1_lat_mst2slv", 64'(slv_cyc[0] - mst_cyc[0]), 1);
    endtask

    initial begin
        logic        exp_u [4];
        logic [63:0] held;
        rst_i = 1'b1; tagctrl_desc_valid_i = 0; tagctrl_desc_i = '0;
        tagc_req_ready_i = 0; tagc_rsp_valid_i = 0; tagc_rsp_i = '0;
        r_chan_mst_valid_i = 0; r_chan_mst_i = '0; r_chan_slv_ready_i = 0;
        repeat (3) step();
        rst_i = 1'b0;
        step();
        chk("rst_desc_ready", tagctrl_desc_ready_o, 1);
        chk("rst_req_valid", tagc_req_valid_o, 0);
        chk("rst_rsp_ready", tagc_rsp_ready_o, 0);
        chk("rst_mst_ready", r_chan_mst_ready_o, 0);
        chk("rst_slv_valid", r_chan_slv_valid_o, 0);

        test1();

        // Four beats within one tag word: tags 0b01 -> users 1,1,0,0.
        clr();
        push_tag(64'h1, 2'b00);
        for (int i = 0; i < 4; i++) push_beat(64'h100 + 64'(i), 2'b00, i == 3);
        send_desc(4'h1, 32'h1000, 8'd3);
        wait_beats(4, 60);
        exp_u = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_user%0d", i), got_q[i].user, exp_u[i]);
            chk($sformatf("t2_data%0d", i), got_q[i].data, 64'h100 + 64'(i));
        end
        chk("t2_last", got_q[3].last, 1);
        chk("t2_nreq", 64'(req_log.size()), 1);

        // Burst crossing a tag word boundary: second fetch before beat 1.
        clr();
        push_tag(64'h8000_0000_0000_0000, 2'b00);
        push_tag(64'h0, 2'b00);
        push_beat(64'h300, 2'b00, 1'b0);
        push_beat(64'h301, 2'b00, 1'b1);
        send_desc(4'h2, 32'h13F8, 8'd1);
        wait_beats(2, 60);
        chk("t3_req0", req_log[0], 32'h1000);
        chk("t3_req1", req_log[1], 32'h1400);
        chk("t3_user0", got_q[0].user, 1);
        chk("t3_user1", got_q[1].user, 0);
        chk("t3_stall0", 64'(got_req[0]), 1);
        chk("t3_stall1", 64'(got_req[1]), 2);

        // Tag fetch error poisons every beat.
        clr();
        push_tag(64'hFFFF, 2'b10);
        push_beat(64'h400, 2'b00, 1'b0);
        push_beat(64'h401, 2'b00, 1'b1);
        send_desc(4'h4, 32'h1000, 8'd1);
        wait_beats(2, 60);
        chk("t4a_resp0", got_q[0].resp, 2);
        chk("t4a_resp1", got_q[1].resp, 2);

        // Memory DECERR on the second beat only.
        clr();
        push_tag(64'h0, 2'b00);
        push_beat(64'h410, 2'b00, 1'b0);
        push_beat(64'h411, 2'b11, 1'b0);
        push_beat(64'h412, 2'b00, 1'b1);
        send_desc(4'h5, 32'h1000, 8'd2);
        wait_beats(3, 60);
        chk("t4b_resp0", got_q[0].resp, 0);
        chk("t4b_resp1", got_q[1].resp, 3);
        chk("t4b_resp2", got_q[2].resp, 0);

        // Slave backpressure: skid fills, memory ready drops, nothing lost.
        clr();
        push_tag(64'hFFFF, 2'b00);
        for (int i = 0; i < 8; i++) push_beat(64'h500 + 64'(i), 2'b00, i == 7);
        send_desc(4'h6, 32'h3000, 8'd7);
        for (int k = 0; k < 40 && got_q.size() < 1; k++) step();
        slv_hold = 1;
        repeat (5) step();
        chk("t5_mst_ready_low", r_chan_mst_ready_o, 0);
        chk("t5_slv_valid", r_chan_slv_valid_o, 1);
        held = r_chan_slv_o.data;
        step();
        chk("t5_hold_stable", r_chan_slv_o.data, held);
        slv_hold = 0;
        wait_beats(8, 80);
        chk("t5_count", 64'(got_q.size()), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t5_data%0d", i), got_q[i].data, 64'h500 + 64'(i));
        chk("t5_last", got_q[7].last, 1);

        // Reset mid-burst, then a fresh single-beat burst.
        clr();
        push_tag(64'hFFFF, 2'b00);
        for (int i = 0; i < 8; i++) push_beat(64'h600 + 64'(i), 2'b00, i == 7);
        send_desc(4'h7, 32'h2000, 8'd7);
        for (int k = 0; k < 40 && got_q.size() < 2; k++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("t6_req_valid", tagc_req_valid_o, 0);
        chk("t6_rsp_ready", tagc_rsp_ready_o, 0);
        chk("t6_mst_ready", r_chan_mst_ready_o, 0);
        chk("t6_slv_valid", r_chan_slv_valid_o, 0);
        chk("t6_idle", tagctrl_desc_ready_o, 1);
        desc_pend = 0;
        clr();
        step();
        test1();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
